// File: rtl/timer_ctrl_if.sv
// Signal bundle between the cooking-timer controller and its keypad, door
// sensor, tick source and mm:ss down-counter chain.
`timescale 1ns/1ps

interface timer_ctrl_if;
   logic        key_valid;
   logic [3:0]  key_digit;
   logic        start;
   logic        stop_clear;
   logic        door_closed;
   logic        tick;
   logic        timer_zero;
   logic [15:0] preset;
   logic        load;
   logic        enablen;
   logic        cook_on;
   logic        done;
   logic [2:0]  state;

   // Keypad / sensor / counter side.
   modport master (
      output key_valid, key_digit, start, stop_clear, door_closed, tick, timer_zero,
      input  preset, load, enablen, cook_on, done, state
   );

   // Controller side.
   modport slave (
      input  key_valid, key_digit, start, stop_clear, door_closed, tick, timer_zero,
      output preset, load, enablen, cook_on, done, state
   );
endinterface

// File: rtl/timer_ctrl.sv
// Cooking-timer controller: BCD keypad entry, load/run/pause sequencing of an
// external mm:ss down-counter chain, and a tick-timed DONE indication.
`timescale 1ns/1ps

module timer_ctrl #(
   parameter int unsigned DONE_TICKS = 3   // legal 1..15
) (
   input  logic         clk,
   input  logic         rst,
   timer_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_LOAD  = 3'd2,
      S_RUN   = 3'd3,
      S_PAUSE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [3:0] LAST_TICK = 4'(DONE_TICKS - 1);

   state_t      state_q, state_d;
   logic [15:0] preset_q, preset_d;
   logic [3:0]  tick_cnt_q, tick_cnt_d;

   logic        key_ok;
   logic [15:0] preset_shift;

   assign key_ok       = bus.key_valid && (bus.key_digit <= 4'd9);
   assign preset_shift = {preset_q[11:0], bus.key_digit};

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         preset_q   <= 16'h0000;
         tick_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         preset_q   <= preset_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path through
   // the block leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d    = state_q;
      preset_d   = preset_q;
      tick_cnt_d = tick_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (key_ok) begin
               preset_d = preset_shift;
               state_d  = S_ENTRY;
            end
         end

         S_ENTRY: begin
            // start owns the cycle even when it cannot launch the run.
            if (bus.start) begin
               if (bus.door_closed && (preset_q != 16'h0000))
                  state_d = S_LOAD;
            end else if (bus.stop_clear) begin
               preset_d = 16'h0000;
               state_d  = S_IDLE;
            end else if (key_ok) begin
               preset_d = preset_shift;
            end
         end

         S_LOAD: begin
            state_d = S_RUN;
         end

         S_RUN: begin
            if (bus.timer_zero) begin
               tick_cnt_d = 4'd0;
               state_d    = S_DONE;
            end else if (!bus.door_closed || bus.stop_clear) begin
               state_d = S_PAUSE;
            end
         end

         S_PAUSE: begin
            if (bus.stop_clear) begin
               preset_d = 16'h0000;
               state_d  = S_IDLE;
            end else if (bus.start && bus.door_closed) begin
               state_d = S_RUN;
            end
         end

         S_DONE: begin
            if (bus.stop_clear) begin
               preset_d = 16'h0000;
               state_d  = S_IDLE;
            end else if (bus.tick) begin
               if (tick_cnt_q == LAST_TICK) begin
                  tick_cnt_d = 4'd0;
                  preset_d   = 16'h0000;
                  state_d    = S_IDLE;
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Everything except enablen is a pure decode of registered state.
   assign bus.preset  = preset_q;
   assign bus.state   = state_q;
   assign bus.load    = (state_q == S_LOAD);
   assign bus.cook_on = (state_q == S_RUN);
   assign bus.done    = (state_q == S_DONE);

   // Combinational so the counter decrements on the tick cycle itself.
   assign bus.enablen = (state_q == S_RUN)
                      ? !(bus.tick && bus.door_closed && !bus.timer_zero)
                      : 1'b1;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: table-driven cycle vectors with a
// scoreboard queue, plus hand-written runs for the 00:99 count and async reset.
`timescale 1ns/1ps

module tb_timer_ctrl;

   localparam logic [2:0] IDL = 3'd0, ENT = 3'd1, LDS = 3'd2,
                          RUN = 3'd3, PAU = 3'd4, DON = 3'd5;

   typedef struct packed {
      logic        kv;
      logic [3:0]  kd;
      logic        st;
      logic        sc;
      logic        dc;
      logic        tk;
      logic        tz;
      logic        en_n;     // expected enablen before the edge
      logic [2:0]  s;        // expected state after the edge
      logic [15:0] p;        // expected preset after the edge
   } vec_t;

   typedef struct packed {
      logic [2:0]  s;
      logic [15:0] p;
   } exp_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];
   exp_t sb_q[$];

   timer_ctrl_if bus ();

   timer_ctrl #(.DONE_TICKS(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic kv, input logic [3:0] kd, input logic st,
                              input logic sc, input logic dc, input logic tk,
                              input logic tz, input logic en_n, input logic [2:0] s,
                              input logic [15:0] p);
      vec_t r;
      r = '{kv: kv, kd: kd, st: st, sc: sc, dc: dc, tk: tk, tz: tz,
            en_n: en_n, s: s, p: p};
      return r;
   endfunction

   task automatic drive_idle();
      bus.key_valid   = 1'b0;
      bus.key_digit   = 4'd0;
      bus.start       = 1'b0;
      bus.stop_clear  = 1'b0;
      bus.door_closed = 1'b1;
      bus.tick        = 1'b0;
      bus.timer_zero  = 1'b0;
   endtask

   task automatic check_regs(input string tag, input exp_t e);
      check({tag, " state"},   16'(bus.state),   16'(e.s));
      check({tag, " preset"},  bus.preset,       e.p);
      check({tag, " load"},    16'(bus.load),    16'(e.s == LDS));
      check({tag, " cook_on"}, 16'(bus.cook_on), 16'(e.s == RUN));
      check({tag, " done"},    16'(bus.done),    16'(e.s == DON));
   endtask

   // Entered just after a falling edge; returns at the next falling edge.
   task automatic step(input vec_t t, input string tag);
      exp_t e;
      bus.key_valid   = t.kv;
      bus.key_digit   = t.kd;
      bus.start       = t.st;
      bus.stop_clear  = t.sc;
      bus.door_closed = t.dc;
      bus.tick        = t.tk;
      bus.timer_zero  = t.tz;
      #1;
      check({tag, " enablen"}, 16'(bus.enablen), 16'(t.en_n));
      sb_q.push_back('{s: t.s, p: t.p});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_regs(tag, e);
      @(negedge clk);
   endtask

   task automatic reset_check(input string tag);
      check({tag, " state"},   16'(bus.state),   16'(IDL));
      check({tag, " preset"},  bus.preset,       16'h0000);
      check({tag, " load"},    16'(bus.load),    16'd0);
      check({tag, " enablen"}, 16'(bus.enablen), 16'd1);
      check({tag, " cook_on"}, 16'(bus.cook_on), 16'd0);
      check({tag, " done"},    16'(bus.done),    16'd0);
   endtask

   initial begin
      int   remaining;
      int   pulses;
      int   bad;
      logic reached;
      logic en_s;

      drive_idle();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1 reset_check("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Keys 1,3,0 then start: load once, enable only on ticks, DONE for 3 ticks.
      tbl.push_back(v(1, 4'd1, 0, 0, 1, 0, 0, 1, ENT, 16'h0001));
      tbl.push_back(v(1, 4'd3, 0, 0, 1, 0, 0, 1, ENT, 16'h0013));
      tbl.push_back(v(1, 4'd0, 0, 0, 1, 0, 0, 1, ENT, 16'h0130));
      tbl.push_back(v(0, 4'd0, 1, 0, 1, 0, 0, 1, LDS, 16'h0130));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 0, 0, 1, RUN, 16'h0130));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 0, RUN, 16'h0130));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 0, 0, 1, RUN, 16'h0130));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 0, RUN, 16'h0130));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 1, 1, DON, 16'h0130));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, DON, 16'h0130));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 0, 0, 1, DON, 16'h0130));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, DON, 16'h0130));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, IDL, 16'h0000));
      // Illegal keys, five-digit entry, door-open start, ENTRY priorities.
      tbl.push_back(v(1, 4'd12, 0, 0, 1, 0, 0, 1, IDL, 16'h0000));
      tbl.push_back(v(0, 4'd0,  1, 0, 1, 0, 0, 1, IDL, 16'h0000));
      tbl.push_back(v(1, 4'd1,  0, 0, 1, 0, 0, 1, ENT, 16'h0001));
      tbl.push_back(v(1, 4'd2,  0, 0, 1, 0, 0, 1, ENT, 16'h0012));
      tbl.push_back(v(1, 4'd3,  0, 0, 1, 0, 0, 1, ENT, 16'h0123));
      tbl.push_back(v(1, 4'd4,  0, 0, 1, 0, 0, 1, ENT, 16'h1234));
      tbl.push_back(v(1, 4'd5,  0, 0, 1, 0, 0, 1, ENT, 16'h2345));
      tbl.push_back(v(1, 4'd12, 0, 0, 1, 0, 0, 1, ENT, 16'h2345));
      tbl.push_back(v(0, 4'd0,  1, 0, 0, 0, 0, 1, ENT, 16'h2345));
      tbl.push_back(v(0, 4'd0,  1, 1, 0, 0, 0, 1, ENT, 16'h2345));
      tbl.push_back(v(1, 4'd7,  1, 0, 0, 0, 0, 1, ENT, 16'h2345));
      tbl.push_back(v(1, 4'd7,  0, 1, 1, 0, 0, 1, IDL, 16'h0000));
      tbl.push_back(v(1, 4'd0,  0, 0, 1, 0, 0, 1, ENT, 16'h0000));
      tbl.push_back(v(0, 4'd0,  1, 0, 1, 0, 0, 1, ENT, 16'h0000));
      tbl.push_back(v(0, 4'd0,  0, 1, 1, 0, 0, 1, IDL, 16'h0000));
      // Door opens mid-run, ticks while paused, resume without reload.
      tbl.push_back(v(1, 4'd5, 0, 0, 1, 0, 0, 1, ENT, 16'h0005));
      tbl.push_back(v(0, 4'd0, 1, 0, 1, 0, 0, 1, LDS, 16'h0005));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 0, 1, 1, RUN, 16'h0005));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 0, RUN, 16'h0005));
      tbl.push_back(v(0, 4'd0, 0, 0, 0, 0, 0, 1, PAU, 16'h0005));
      tbl.push_back(v(0, 4'd0, 0, 0, 0, 1, 0, 1, PAU, 16'h0005));
      tbl.push_back(v(0, 4'd0, 0, 0, 0, 1, 0, 1, PAU, 16'h0005));
      tbl.push_back(v(0, 4'd0, 0, 0, 0, 1, 0, 1, PAU, 16'h0005));
      tbl.push_back(v(1, 4'd7, 0, 0, 0, 0, 0, 1, PAU, 16'h0005));
      tbl.push_back(v(0, 4'd0, 1, 0, 0, 0, 0, 1, PAU, 16'h0005));
      tbl.push_back(v(0, 4'd0, 1, 0, 1, 0, 0, 1, RUN, 16'h0005));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 0, RUN, 16'h0005));
      tbl.push_back(v(0, 4'd0, 0, 1, 1, 1, 0, 0, PAU, 16'h0005));
      tbl.push_back(v(0, 4'd0, 1, 1, 1, 0, 0, 1, IDL, 16'h0000));
      // timer_zero and door open together: timer_zero wins.
      tbl.push_back(v(1, 4'd8, 0, 0, 1, 0, 0, 1, ENT, 16'h0008));
      tbl.push_back(v(0, 4'd0, 1, 0, 1, 0, 0, 1, LDS, 16'h0008));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 0, 0, 1, RUN, 16'h0008));
      tbl.push_back(v(0, 4'd0, 0, 0, 0, 1, 1, 1, DON, 16'h0008));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, DON, 16'h0008));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, DON, 16'h0008));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, IDL, 16'h0000));
      // stop_clear in DONE, then a fresh DONE must restart its tick count.
      tbl.push_back(v(1, 4'd9, 0, 0, 1, 0, 0, 1, ENT, 16'h0009));
      tbl.push_back(v(0, 4'd0, 1, 0, 1, 0, 0, 1, LDS, 16'h0009));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 0, 0, 1, RUN, 16'h0009));
      tbl.push_back(v(1, 4'd3, 0, 0, 1, 0, 0, 1, RUN, 16'h0009));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 0, 1, 1, DON, 16'h0009));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, DON, 16'h0009));
      tbl.push_back(v(0, 4'd0, 0, 1, 1, 0, 0, 1, IDL, 16'h0000));
      tbl.push_back(v(1, 4'd9, 0, 0, 1, 0, 0, 1, ENT, 16'h0009));
      tbl.push_back(v(0, 4'd0, 1, 0, 1, 0, 0, 1, LDS, 16'h0009));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 0, 0, 1, RUN, 16'h0009));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 0, 1, 1, DON, 16'h0009));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, DON, 16'h0009));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, DON, 16'h0009));
      tbl.push_back(v(0, 4'd0, 0, 0, 1, 1, 0, 1, IDL, 16'h0000));

      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

      // 00:99 run against a behavioural down-counter driven by enablen.
      step(v(1, 4'd0, 0, 0, 1, 0, 0, 1, ENT, 16'h0000), "p99 k0a");
      step(v(1, 4'd0, 0, 0, 1, 0, 0, 1, ENT, 16'h0000), "p99 k0b");
      step(v(1, 4'd9, 0, 0, 1, 0, 0, 1, ENT, 16'h0009), "p99 k9a");
      step(v(1, 4'd9, 0, 0, 1, 0, 0, 1, ENT, 16'h0099), "p99 k9b");
      step(v(0, 4'd0, 1, 0, 1, 0, 0, 1, LDS, 16'h0099), "p99 start");
      step(v(0, 4'd0, 0, 0, 1, 0, 0, 1, RUN, 16'h0099), "p99 run");
      remaining = 99;
      pulses    = 0;
      bad       = 0;
      reached   = 1'b0;
      for (int c = 0; c < 600 && !reached; c++) begin
         drive_idle();
         bus.tick       = (c % 2 == 1);
         bus.timer_zero = (remaining == 0);
         #1;
         en_s = bus.enablen;
         if (!en_s) begin
            pulses++;
            if (!bus.tick) bad++;
         end
         @(posedge clk);
         if (!en_s && remaining > 0) remaining--;
         #1;
         if (bus.state == DON) reached = 1'b1;
         @(negedge clk);
      end
      check("p99 reached DONE", 16'(reached), 16'd1);
      check("p99 enable pulses", 16'(pulses), 16'd99);
      check("p99 enable off-tick", 16'(bad), 16'd0);
      check("p99 preset held", bus.preset, 16'h0099);
      step(v(0, 4'd0, 0, 1, 1, 0, 0, 1, IDL, 16'h0000), "p99 clear");

      // Asynchronous reset between edges during RUN; key waiting on release.
      step(v(1, 4'd4, 0, 0, 1, 0, 0, 1, ENT, 16'h0004), "rr k4");
      step(v(0, 4'd0, 1, 0, 1, 0, 0, 1, LDS, 16'h0004), "rr start");
      step(v(0, 4'd0, 0, 0, 1, 0, 0, 1, RUN, 16'h0004), "rr run");
      bus.tick = 1'b1;
      #1 check("rr pre enablen", 16'(bus.enablen), 16'd0);
      #1 rst = 1'b0;
      #1 reset_check("rr async");
      @(negedge clk);
      bus.tick      = 1'b0;
      bus.key_valid = 1'b1;
      bus.key_digit = 4'd6;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check_regs("rr first edge", '{s: ENT, p: 16'h0006});
      @(negedge clk);
      drive_idle();

      // Asynchronous reset during DONE.
      step(v(0, 4'd0, 1, 0, 1, 0, 0, 1, LDS, 16'h0006), "rd start");
      step(v(0, 4'd0, 0, 0, 1, 0, 0, 1, RUN, 16'h0006), "rd run");
      step(v(0, 4'd0, 0, 0, 1, 0, 1, 1, DON, 16'h0006), "rd done");
      #2 rst = 1'b0;
      #1 reset_check("rd async");
      @(negedge clk);
      drive_idle();
      #2 rst = 1'b1;
      @(posedge clk);
      #1 reset_check("rd release");
      @(negedge clk);

      if (sb_q.size() != 0) check("scoreboard drained", 16'(sb_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
